// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer: double-buffered 16x16 binary image feeder for the LGN
// MNIST classifier. It streams the front bank one byte per clock. It samples the
// classifier result at a fixed byte offset in each frame. A host can load the
// back bank and commit it without disturbing a frame that is already streaming.
// Optional build macro: FRAME_TEST_PATTERN_EN adds i_test_sel, which replaces
// the pixel stream with an 8'hAA/8'h55 alternating pattern.
module mnist_frame_streamer #(
  parameter int FRAME_BYTES    = 32,
  parameter int CAPTURE_OFFSET = 1,
  parameter int INDEX_W        = 4,
  localparam int AW            = $clog2(FRAME_BYTES)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stream_en,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [7:0]         i_wr_data,
  input  logic               i_commit,
`ifdef FRAME_TEST_PATTERN_EN
  input  logic               i_test_sel,
`endif
  input  logic [INDEX_W-1:0] i_cls_index,
  input  logic [7:0]         i_cls_value,
  output logic               o_wr_busy,
  output logic [7:0]         o_pixel_byte,
  output logic [AW-1:0]      o_byte_idx,
  output logic               o_frame_start,
  output logic [INDEX_W-1:0] o_result_index,
  output logic [7:0]         o_result_value,
  output logic               o_result_valid,
  output logic [15:0]        o_frame_count
);

  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(FRAME_BYTES - 1);
  localparam logic [AW-1:0] CAP_IDX  = AW'(CAPTURE_OFFSET);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_front_sel;
  logic                 r_wr_busy;
  logic [AW-1:0]        r_rd_ptr;
  logic [7:0]           r_pixel_byte;
  logic [AW-1:0]        r_byte_idx;
  logic                 r_frame_start;
  logic [INDEX_W-1:0]   r_result_index;
  logic [7:0]           r_result_value;
  logic                 r_result_valid;
  logic [15:0]          r_frame_count;

  // Bank storage is deliberately left unreset; only the select/pointer state resets.
  logic [7:0]           r_bank0 [FRAME_BYTES];
  logic [7:0]           r_bank1 [FRAME_BYTES];

  logic                 w_wrap;
  logic                 w_wr_ok;
  logic [7:0]           w_front_byte;
  logic [7:0]           w_pixel_next;

  // An enabled edge with the pointer at the last byte is the frame boundary.
  assign w_wrap  = i_stream_en && (r_rd_ptr == PTR_LAST);
  assign w_wr_ok = i_wr_en && !r_wr_busy;

  // Read the front bank at the current read pointer.
  always_comb begin
    w_front_byte = 8'h00;
    if (r_front_sel) begin
      w_front_byte = r_bank1[r_rd_ptr];
    end else begin
      w_front_byte = r_bank0[r_rd_ptr];
    end
  end

  // Choose the next pixel source: front bank or the built-in test pattern.
  always_comb begin
    w_pixel_next = w_front_byte;
`ifdef FRAME_TEST_PATTERN_EN
    if (i_test_sel) begin
      w_pixel_next = r_rd_ptr[0] ? 8'h55 : 8'hAA;
    end else begin
      w_pixel_next = w_front_byte;
    end
`endif
  end

  // Host writes go only to the back bank and are refused while a swap is pending.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      if (r_front_sel) begin
        r_bank0[i_wr_addr] <= i_wr_data;
      end else begin
        r_bank1[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Commit/swap FSM: a commit arms the swap, and the next enabled wrap performs it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_front_sel <= 1'b0;
      r_wr_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_commit) begin
            r_state   <= ST_PENDING;
            r_wr_busy <= 1'b1;
          end
        end
        ST_PENDING: begin
          // A commit seen in the same cycle as the wrap only arms; it never swaps now.
          if (w_wrap) begin
            r_state     <= ST_IDLE;
            r_wr_busy   <= 1'b0;
            r_front_sel <= ~r_front_sel;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_wr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Streaming datapath: pointer, registered pixel/index, result capture and frame count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr       <= PTR_ZERO;
      r_pixel_byte   <= 8'h00;
      r_byte_idx     <= PTR_ZERO;
      r_frame_start  <= 1'b0;
      r_result_index <= '0;
      r_result_value <= 8'h00;
      r_result_valid <= 1'b0;
      r_frame_count  <= 16'h0000;
    end else if (i_stream_en) begin
      r_rd_ptr      <= r_rd_ptr + PTR_ONE;
      r_pixel_byte  <= w_pixel_next;
      r_byte_idx    <= r_rd_ptr;
      r_frame_start <= (r_rd_ptr == PTR_ZERO);
      if (r_byte_idx == CAP_IDX) begin
        r_result_index <= i_cls_index;
        r_result_value <= i_cls_value;
        r_result_valid <= 1'b1;
      end else begin
        r_result_valid <= 1'b0;
      end
      if (w_wrap) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end else begin
      // Stalled: everything holds except the one-cycle valid pulse.
      r_result_valid <= 1'b0;
    end
  end

  assign o_wr_busy      = r_wr_busy;
  assign o_pixel_byte   = r_pixel_byte;
  assign o_byte_idx     = r_byte_idx;
  assign o_frame_start  = r_frame_start;
  assign o_result_index = r_result_index;
  assign o_result_value = r_result_value;
  assign o_result_valid = r_result_valid;
  assign o_frame_count  = r_frame_count;

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Directed self-checking bench for mnist_frame_streamer (default build).
`timescale 1ns/1ps
module tb_mnist_frame_streamer;

  localparam int AW = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stream_en = 1'b0;
  logic         wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]   wr_data = 8'h00;
  logic         commit = 1'b0;
  logic [3:0]   cls_index = 4'h0;
  logic [7:0]   cls_value = 8'h00;
`ifdef FRAME_TEST_PATTERN_EN
  logic         test_sel = 1'b0;
`endif
  logic         wr_busy;
  logic [7:0]   pixel_byte;
  logic [AW-1:0] byte_idx;
  logic         frame_start;
  logic [3:0]   result_index;
  logic [7:0]   result_value;
  logic         result_valid;
  logic [15:0]  frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  mnist_frame_streamer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stream_en    (stream_en),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_commit       (commit),
`ifdef FRAME_TEST_PATTERN_EN
    .i_test_sel     (test_sel),
`endif
    .i_cls_index    (cls_index),
    .i_cls_value    (cls_value),
    .o_wr_busy      (wr_busy),
    .o_pixel_byte   (pixel_byte),
    .o_byte_idx     (byte_idx),
    .o_frame_start  (frame_start),
    .o_result_index (result_index),
    .o_result_value (result_value),
    .o_result_valid (result_valid),
    .o_frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({wr_busy, pixel_byte, byte_idx, frame_start, result_index, result_value,
         result_valid, frame_count} !== 47'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b pix=%h idx=%0d fs=%b ri=%h rv=%h val=%b fc=%0d required all zero",
               wr_busy, pixel_byte, byte_idx, frame_start, result_index, result_value, result_valid, frame_count);
    end
    rst = 1'b0;
    tick();
  endtask

  // Load bank1 with byte n = n, commit, stream two frames.
  task automatic test_load_commit();
    for (int n = 0; n < 32; n++) begin
      wr_en = 1'b1; wr_addr = AW'(n); wr_data = 8'(n);
      tick();
    end
    wr_en = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n_checks++;
    if (wr_busy !== 1'b1) begin
      n_fail++; $display("FAIL commit_busy: got %b required 1", wr_busy);
    end
    stream_en = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k <= 32) begin
        n_checks++;
        if (wr_busy !== (k < 32)) begin
          n_fail++; $display("FAIL busy_until_wrap k=%0d: got %b required %b", k, wr_busy, (k < 32));
        end
      end else begin
        n_checks++;
        if (pixel_byte !== 8'(k - 33) || byte_idx !== AW'(k - 33)) begin
          n_fail++; $display("FAIL new_frame k=%0d: got pix=%h idx=%0d required pix=%h idx=%0d",
                             k, pixel_byte, byte_idx, 8'(k - 33), k - 33);
        end
        n_checks++;
        if (frame_start !== (k == 33)) begin
          n_fail++; $display("FAIL frame_start k=%0d: got %b required %b", k, frame_start, (k == 33));
        end
      end
    end
    n_checks++;
    if (frame_count !== 16'd2) begin
      n_fail++; $display("FAIL frame_count_2: got %0d required 2", frame_count);
    end
  endtask

  // Result capture: valid exactly when byte_idx is CAPTURE_OFFSET+1, twice per 64 cycles.
  task automatic test_capture();
    int pulses;
    pulses = 0;
    cls_index = 4'd5;
    cls_value = 8'h3C;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (result_valid === 1'b1) pulses++;
      n_checks++;
      if (result_valid !== (byte_idx == 5'd2)) begin
        n_fail++; $display("FAIL capture_timing k=%0d: got valid=%b idx=%0d required valid only at idx 2",
                           k, result_valid, byte_idx);
      end
    end
    n_checks++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL capture_count: got %0d required 2", pulses);
    end
    n_checks++;
    if (result_index !== 4'd5 || result_value !== 8'h3C) begin
      n_fail++; $display("FAIL capture_value: got %h/%h required 5/3c", result_index, result_value);
    end
    n_checks++;
    if (frame_count !== 16'd4) begin
      n_fail++; $display("FAIL frame_count_4: got %0d required 4", frame_count);
    end
  endtask

  // Commit arriving on the wrap edge defers the swap by one full frame.
  task automatic test_commit_at_wrap();
    stream_en = 1'b0;
    for (int n = 0; n < 32; n++) begin
      wr_en = 1'b1; wr_addr = AW'(n); wr_data = 8'h80 | 8'(n);
      tick();
    end
    wr_en = 1'b0;
    stream_en = 1'b1;
    for (int k = 0; k < 31; k++) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n_checks++;
    if (wr_busy !== 1'b1 || byte_idx !== 5'd31 || pixel_byte !== 8'd31) begin
      n_fail++; $display("FAIL wrap_commit: got busy=%b idx=%0d pix=%h required 1/31/1f", wr_busy, byte_idx, pixel_byte);
    end
    for (int k = 1; k <= 64; k++) begin
      tick();
      n_checks++;
      if (k <= 32) begin
        if (pixel_byte !== 8'(k - 1) || wr_busy !== (k < 32)) begin
          n_fail++; $display("FAIL old_front k=%0d: got pix=%h busy=%b required pix=%h busy=%b",
                             k, pixel_byte, wr_busy, 8'(k - 1), (k < 32));
        end
      end else begin
        if (pixel_byte !== (8'h80 | 8'(k - 33))) begin
          n_fail++; $display("FAIL swapped_front k=%0d: got %h required %h", k, pixel_byte, 8'h80 | 8'(k - 33));
        end
      end
    end
    n_checks++;
    if (frame_count !== 16'd7) begin
      n_fail++; $display("FAIL frame_count_7: got %0d required 7", frame_count);
    end
  endtask

  // Write with commit lands; write and repeated commit while busy are ignored.
  task automatic test_write_while_busy();
    logic [7:0] exp;
    stream_en = 1'b0;
    commit = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'hE5;
    tick();
    commit = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'hFF;
    tick();
    commit = 1'b0; wr_en = 1'b0;
    n_checks++;
    if (wr_busy !== 1'b1) begin
      n_fail++; $display("FAIL repeat_commit_busy: got %b required 1", wr_busy);
    end
    stream_en = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k >= 33) begin
        exp = (k - 33 == 5) ? 8'hE5 : 8'(k - 33);
        n_checks++;
        if (pixel_byte !== exp) begin
          n_fail++; $display("FAIL busy_write k=%0d: got %h required %h", k, pixel_byte, exp);
        end
      end
    end
    n_checks++;
    if (frame_count !== 16'd9 || wr_busy !== 1'b0) begin
      n_fail++; $display("FAIL after_busy_write: got fc=%0d busy=%b required 9/0", frame_count, wr_busy);
    end
  endtask

  // Stall at byte 7 for 10 cycles; everything holds and no extra capture pulse.
  task automatic test_stall();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (result_valid === 1'b1) pulses++;
    end
    stream_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (result_valid === 1'b1) pulses++;
      n_checks++;
      if (pixel_byte !== 8'd7 || byte_idx !== 5'd7 || frame_count !== 16'd9) begin
        n_fail++; $display("FAIL stall_hold k=%0d: got pix=%h idx=%0d fc=%0d required 07/7/9",
                           k, pixel_byte, byte_idx, frame_count);
      end
    end
    stream_en = 1'b1;
    tick();
    if (result_valid === 1'b1) pulses++;
    n_checks++;
    if (pixel_byte !== 8'd8 || byte_idx !== 5'd8) begin
      n_fail++; $display("FAIL stall_resume: got pix=%h idx=%0d required 08/8", pixel_byte, byte_idx);
    end
    tick();
    if (result_valid === 1'b1) pulses++;
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL stall_pulses: got %0d required 1", pulses);
    end
  endtask

  // Asynchronous reset at byte 20, then restart from bank 0.
  task automatic test_reset_mid();
    while (byte_idx !== 5'd20 && n_checks < 100000) begin
      tick();
      if (byte_idx > 5'd20) break;
    end
    n_checks++;
    if (byte_idx !== 5'd20) begin
      n_fail++; $display("FAIL reach_byte20: got %0d required 20", byte_idx);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wr_busy, pixel_byte, byte_idx, frame_start, result_index, result_value,
         result_valid, frame_count} !== 47'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b pix=%h idx=%0d fs=%b ri=%h rv=%h val=%b fc=%0d required all zero",
               wr_busy, pixel_byte, byte_idx, frame_start, result_index, result_value, result_valid, frame_count);
    end
    tick();
    rst = 1'b0;
    for (int m = 0; m < 4; m++) begin
      tick();
      n_checks++;
      if (pixel_byte !== (8'h80 | 8'(m)) || byte_idx !== AW'(m) || frame_count !== 16'd0) begin
        n_fail++; $display("FAIL restart m=%0d: got pix=%h idx=%0d fc=%0d required %h/%0d/0",
                           m, pixel_byte, byte_idx, frame_count, 8'h80 | 8'(m), m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_capture();
    test_commit_at_wrap();
    test_write_while_busy();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_frame_streamer.md
Name: mnist_frame_streamer

Overview:
Upstream feeder for the LGN MNIST classifier core. Holds a double-buffered 16x16 binary image of 32 bytes and streams it cyclically, one byte per clock, onto the classifier's 8-bit pixel input. Captures the classifier's index/value outputs at a fixed byte offset within each frame. Replaces the hand-coded pattern ROM plus latch logic in the board top, and lets a host or UART loader swap images without glitching a frame in progress.

Parameters:
FRAME_BYTES, 32, bytes per frame; must be a power of two; address width AW = log2(FRAME_BYTES).
CAPTURE_OFFSET, 1, byte_idx value at which cls_index/cls_value are sampled.
INDEX_W, 4, width of the classifier index result.

Ports:
clk  in  1  system clock; the classifier core runs on the same clock.
rst  in  1  asynchronous, active-high reset.
stream_en  in  1  advance the stream by one byte per cycle while high; hold all state while low.
wr_en  in  1  write strobe into the back buffer.
wr_addr  in  AW  back-buffer byte address.
wr_data  in  8  back-buffer byte data.
commit  in  1  single-cycle pulse: request a back/front swap at the next frame boundary.
wr_busy  out  1  high while a commit is pending; writes are ignored while this is high.
pixel_byte  out  8  registered byte driven to the classifier ui_in.
byte_idx  out  AW  index of the byte currently on pixel_byte.
frame_start  out  1  high for the cycle in which byte_idx==0.
cls_index  in  INDEX_W  classifier predicted class.
cls_value  in  8  classifier score output.
result_index  out  INDEX_W  latched class.
result_value  out  8  latched score.
result_valid  out  1  one-cycle pulse when a new result is latched.
frame_count  out  16  count of completed frames; wraps at 16 bits.

Behaviour:
- Reset (async, rst=1): all outputs 0; read counter 0; front buffer select = 0; commit pending cleared. Buffer RAM contents are not reset.
- Two banks of FRAME_BYTES x 8 each. The front bank is read; the back bank is written.
- Read counter rd_ptr (AW bits) increments each cycle while stream_en=1 and wraps FRAME_BYTES-1 -> 0.
- Read latency is 1 cycle. On each enabled edge, pixel_byte <= front[rd_ptr] and byte_idx <= rd_ptr. With stream_en=0, pixel_byte, byte_idx and rd_ptr all hold.
- frame_start = stream_en-qualified registered flag: high in the cycle after the edge that loaded byte 0.
- Capture: on an enabled edge where byte_idx==CAPTURE_OFFSET, result_index <= cls_index, result_value <= cls_value, and result_valid pulses high for exactly one cycle. result_valid is never high for two consecutive cycles.
- frame_count increments on the enabled edge where rd_ptr wraps to 0.
- Writes: when wr_en=1 and wr_busy=0, back[wr_addr] <= wr_data. Writes have no effect on the front bank.
- Commit: a commit pulse sets pending, so wr_busy=1 from the next cycle.
- Swap: on the enabled edge where rd_ptr wraps to 0 and pending=1, the front select toggles and pending clears. The first byte of the next frame already comes from the new front bank; a frame is never mixed across banks.
- commit arriving in the same cycle as the wrap edge: sets pending only. The swap happens at the following wrap, never the current one.
- Repeated commit while pending: no effect.
- wr_en in the same cycle as commit: the write lands, because wr_busy is still 0 in that cycle.
- stream_en=0 with pending=1: the swap is deferred indefinitely.
- rst asserted mid-frame: immediate return to reset state. The next frame starts at byte 0 of bank 0.

State machine:
- IDLE: pending=0; writes allowed. commit -> PENDING.
- PENDING: wr_busy=1. Enabled wrap edge -> IDLE with banks swapped.

Optional Feature:
FRAME_TEST_PATTERN_EN:
- When defined, adds input test_sel (1 bit). While test_sel=1, pixel_byte is driven from a built-in pattern: 8'hAA on even byte_idx and 8'h55 on odd. Banks, writes, commit and capture behave unchanged.
- When not defined, the port is absent and pixel_byte always comes from the front bank.

Test Plan:
- Reset, load back bank with byte n = n, commit, stream 64 cycles -> wr_busy=1 until first wrap; next frame pixel_byte sequence 0x00..0x1F with byte_idx matching; frame_count=2.
- Drive cls_index=4'd5, cls_value=8'h3C -> result_valid pulses once per 32 enabled cycles, one cycle after byte_idx==1; result_index=5, result_value=0x3C.
- Commit in the exact wrap cycle -> front unchanged for that frame; swap at the following wrap.
- Write 0xFF to addr 3 while wr_busy=1 -> after swap, byte 3 still holds the preloaded value.
- Toggle stream_en low for 10 cycles mid-frame (byte_idx=7) -> pixel_byte, byte_idx and frame_count hold; sequence resumes at byte 8; no extra result_valid.
- Assert rst at byte_idx=20 -> all outputs 0 immediately; after release, stream restarts at byte_idx 0 from bank 0; frame_count=0.
